// File: rtl/rr_grant_arb_pkg.sv
// Shared types and helpers for the rr_grant_arb round-robin arbiter and its selector.
package rr_grant_arb_pkg;

    localparam int SRC_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Source index after idx, wrapping N-1 back to 0.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx, input int n);
        return (int'(idx) + 1 >= n) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin picker: first requester at or after ptr (with wrap), skipping excl.
module rr_next_sel
    import rr_grant_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     req,
    input  logic [SRC_W-1:0] ptr,
    input  logic [N-1:0]     excl,
    output logic [N-1:0]     onehot,
    output logic [SRC_W-1:0] idx,
    output logic             any
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [SRC_W:0] sum;

    assign cand = req & ~excl;
    assign dbl  = {cand, cand};
    // Rotate so bit 0 of rot is the candidate sitting at ptr.
    assign rot  = N'(dbl >> ptr);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        sum    = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && rot[i]) begin
                any = 1'b1;
                sum = {1'b0, ptr} + (SRC_W+1)'(i);
                if (sum >= (SRC_W+1)'(N)) begin
                    sum = sum - (SRC_W+1)'(N);
                end
                idx = sum[SRC_W-1:0];
            end
        end
        if (any) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/rr_grant_arb.sv
// Round-robin grant arbiter with registered data merge toward a shared sink.
// Optional per-holder burst limit enabled by defining ARB_BURST_LIMIT_EN.
module rr_grant_arb
    import rr_grant_arb_pkg::*;
#(
    parameter int N         = 3,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [N-1:0]         i_Req,
    output logic [N-1:0]         o_Grant,
    input  logic [N-1:0]         i_Valid,
    input  logic [N*WIDTH-1:0]   i_Data,
    input  logic                 i_Ready,
    output logic                 o_Valid,
    output logic [WIDTH-1:0]     o_Data,
    output logic [SRC_W-1:0]     o_Src,
    output logic                 o_Err
);

    if (N < 2 || N > 8 || WIDTH < 1 || MAX_BURST < 1) begin : g_bad_cfg
        $error("rr_grant_arb: unsupported parameter set");
    end

    state_e             state_q, state_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [SRC_W-1:0]   gidx_q, gidx_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               err_q, err_d;

    logic [N-1:0]       sel_onehot;
    logic [SRC_W-1:0]   sel_idx;
    logic               sel_any;
    logic               holder_req;
    logic               force_off;
    logic [WIDTH-1:0]   mux_data;

    // While granted, the holder is excluded so a release never re-picks it in the same cycle.
    rr_next_sel #(.N(N)) u_next_sel (
        .req    (i_Req),
        .ptr    (ptr_q),
        .excl   (grant_q),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    assign holder_req = |(i_Req & grant_q);

`ifdef ARB_BURST_LIMIT_EN
    localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST - 1);

    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign force_off = (burst_cnt_q == BURST_LIM) && |(i_Req & ~grant_q);

    // Saturates at the limit so a late competitor takes over on its first request cycle.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (grant_d != grant_q) begin
            burst_cnt_d = '0;
        end else if (i_Ready && state_q == ST_GRANT && burst_cnt_q != BURST_LIM) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign force_off = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a stalled sink freezes the whole arbitration state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        if (i_Ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_any) begin
                        state_d = ST_GRANT;
                        grant_d = sel_onehot;
                        gidx_d  = sel_idx;
                        ptr_d   = wrap_inc(sel_idx, N);
                    end
                end
                ST_GRANT: begin
                    if (!holder_req || force_off) begin
                        if (sel_any) begin
                            grant_d = sel_onehot;
                            gidx_d  = sel_idx;
                            ptr_d   = wrap_inc(sel_idx, N);
                        end else begin
                            state_d = ST_IDLE;
                            grant_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            endcase
        end
    end

    // Outputs and datapath.
    assign o_Grant = grant_q & {N{i_Ready}};

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_q[k]) begin
                mux_data = mux_data | i_Data[k*WIDTH +: WIDTH];
            end
        end

        valid_d = |(i_Valid & o_Grant);
        data_d  = data_q;
        src_d   = src_q;
        if (valid_d) begin
            data_d = mux_data;
            src_d  = gidx_q;
        end
        err_d = err_q | (|(i_Valid & ~o_Grant));
    end

    assign o_Valid = valid_q;
    assign o_Data  = data_q;
    assign o_Src   = src_q;
    assign o_Err   = err_q;

endmodule

// File: tb/tb_rr_grant_arb.sv
// Scoreboard bench for rr_grant_arb (N=3, WIDTH=8); expectations follow ARB_BURST_LIMIT_EN.
module tb_rr_grant_arb;

    logic        CLK;
    logic        Reset;
    logic [2:0]  i_Req;
    logic [2:0]  o_Grant;
    logic [2:0]  i_Valid;
    logic [23:0] i_Data;
    logic        i_Ready;
    logic        o_Valid;
    logic [7:0]  o_Data;
    logic [2:0]  o_Src;
    logic        o_Err;

    typedef struct {
        logic [7:0] data;
        logic [2:0] src;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    rr_grant_arb #(.N(3), .WIDTH(8), .MAX_BURST(4)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .i_Req   (i_Req),
        .o_Grant (o_Grant),
        .i_Valid (i_Valid),
        .i_Data  (i_Data),
        .i_Ready (i_Ready),
        .o_Valid (o_Valid),
        .o_Data  (o_Data),
        .o_Src   (o_Src),
        .o_Err   (o_Err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, check the combinational grant, queue the expected beat.
    task automatic cyc(input logic [2:0] req, input logic [2:0] vld, input logic [7:0] d,
                       input logic rdy, input logic rst, input logic [2:0] expg, input string tag);
        beat_t b;
        Reset   = rst;
        i_Req   = req;
        i_Valid = vld;
        i_Ready = rdy;
        for (int k = 0; k < 3; k++) begin
            i_Data[k*8 +: 8] = (vld[k] && expg[k]) ? d : 8'(8'hA5 + k);
        end
        #1;
        check({tag, "_grant"}, 32'(o_Grant), 32'(expg));
        if (!rst && |(vld & expg)) begin
            b.data = d;
            b.src  = expg[1] ? 3'd1 : (expg[2] ? 3'd2 : 3'd0);
            exp_q.push_back(b);
        end
        @(negedge CLK);
    endtask

    // Monitor: every presented beat must match the oldest expected one.
    always @(negedge CLK) begin
        beat_t e;
        if (o_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_unexpected: got data 0x%0h src %0d expected no beat", o_Data, o_Src);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(o_Data), 32'(e.data));
                check("beat_src", 32'(o_Src), 32'(e.src));
            end
        end
    end

    initial begin
        Reset   = 1'b1;
        i_Req   = '0;
        i_Valid = '0;
        i_Data  = '0;
        i_Ready = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_grant", 32'(o_Grant), 0);
        check("rst_valid", 32'(o_Valid), 0);
        check("rst_data", 32'(o_Data), 0);
        check("rst_src", 32'(o_Src), 0);
        check("rst_err", 32'(o_Err), 0);

        // 1. Single source, one-cycle request->grant latency.
        repeat (3) cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t1_idle");
        cyc(3'b001, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t1_req");
        for (int i = 1; i <= 4; i++) begin
            cyc(3'b001, 3'b001, 8'(i), 1'b1, 1'b0, 3'b001, "t1_beat");
        end
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b001, "t1_drop");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t1_idle2");

        // 2. Contention with all three requesting.
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b1, 3'b000, "t2_rst");
        cyc(3'b111, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t2_req");
`ifdef ARB_BURST_LIMIT_EN
        for (int i = 0; i < 12; i++) begin
            logic [2:0] g;
            g = 3'b001 << (i / 4);
            cyc(3'b111, g, 8'(8'h20 + i), 1'b1, 1'b0, g, "t2_rot");
        end
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b001, "t2_drop");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t2_idle");
`else
        for (int i = 1; i <= 3; i++) begin
            cyc(3'b111, 3'b001, 8'(8'h20 + i), 1'b1, 1'b0, 3'b001, "t2_src0");
        end
        cyc(3'b110, 3'b000, 8'd0, 1'b1, 1'b0, 3'b001, "t2_drop0");
        cyc(3'b110, 3'b010, 8'h31, 1'b1, 1'b0, 3'b010, "t2_src1");
        cyc(3'b110, 3'b010, 8'h32, 1'b1, 1'b0, 3'b010, "t2_src1");
        cyc(3'b100, 3'b000, 8'd0, 1'b1, 1'b0, 3'b010, "t2_drop1");
        cyc(3'b100, 3'b100, 8'h41, 1'b1, 1'b0, 3'b100, "t2_src2");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b100, "t2_drop2");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t2_idle");
`endif

        // 3. Backpressure on a src1 stream.
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b1, 3'b000, "t3_rst");
        cyc(3'b010, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t3_req");
        cyc(3'b010, 3'b010, 8'd5, 1'b1, 1'b0, 3'b010, "t3_beat");
        cyc(3'b010, 3'b010, 8'd6, 1'b1, 1'b0, 3'b010, "t3_beat");
        cyc(3'b010, 3'b000, 8'd0, 1'b0, 1'b0, 3'b000, "t3_stall");
        check("t3_stall_valid", 32'(o_Valid), 0);
        cyc(3'b010, 3'b000, 8'd0, 1'b0, 1'b0, 3'b000, "t3_stall");
        check("t3_stall_valid", 32'(o_Valid), 0);
        cyc(3'b010, 3'b010, 8'd7, 1'b1, 1'b0, 3'b010, "t3_resume");
        cyc(3'b010, 3'b010, 8'd8, 1'b1, 1'b0, 3'b010, "t3_resume");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b010, "t3_drop");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t3_idle");

        // 4. Handover src0 -> src2 without a bubble; drop-cycle beat still forwarded.
        cyc(3'b001, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t4_req");
        cyc(3'b001, 3'b001, 8'd9, 1'b1, 1'b0, 3'b001, "t4_src0");
        cyc(3'b001, 3'b001, 8'd10, 1'b1, 1'b0, 3'b001, "t4_src0");
        cyc(3'b001, 3'b001, 8'd11, 1'b1, 1'b0, 3'b001, "t4_src0");
        cyc(3'b100, 3'b001, 8'd12, 1'b1, 1'b0, 3'b001, "t4_drop");
        for (int i = 13; i <= 16; i++) begin
            cyc(3'b100, 3'b100, 8'(i), 1'b1, 1'b0, 3'b100, "t4_src2");
            check("t4_nobubble", 32'(o_Valid), 1);
        end
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b100, "t4_drop2");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t4_idle");

        // 5. Protocol error is sticky and leaves the data path alone.
        cyc(3'b001, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t5_req");
        cyc(3'b001, 3'b001, 8'h51, 1'b1, 1'b0, 3'b001, "t5_ok");
        check("t5_err_clear", 32'(o_Err), 0);
        cyc(3'b001, 3'b101, 8'h52, 1'b1, 1'b0, 3'b001, "t5_bad");
        check("t5_err_set", 32'(o_Err), 1);
        cyc(3'b001, 3'b001, 8'h53, 1'b1, 1'b0, 3'b001, "t5_after");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b001, "t5_drop");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t5_idle");
        check("t5_err_sticky", 32'(o_Err), 1);

        // 6. Reset during a src1 grant, then re-arbitration from src0.
        cyc(3'b010, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t6_req");
        cyc(3'b010, 3'b010, 8'h61, 1'b1, 1'b0, 3'b010, "t6_src1");
        cyc(3'b010, 3'b010, 8'h62, 1'b1, 1'b0, 3'b010, "t6_src1");
        cyc(3'b010, 3'b010, 8'h63, 1'b1, 1'b1, 3'b010, "t6_rst");
        check("t6_valid", 32'(o_Valid), 0);
        check("t6_data", 32'(o_Data), 0);
        check("t6_src", 32'(o_Src), 0);
        check("t6_err", 32'(o_Err), 0);
        cyc(3'b111, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t6_rearb_req");
        cyc(3'b111, 3'b001, 8'h71, 1'b1, 1'b0, 3'b001, "t6_rearb_src0");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b001, "t6_drop");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t6_idle");
        cyc(3'b000, 3'b000, 8'd0, 1'b1, 1'b0, 3'b000, "t6_idle");

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
